// File: rtl/branch_pkg.sv
// Shared encodings for the branch resolution slice: condition codes, 2-bit
// predictor counter states, the sequential PC step and the counter update rule.
package branch_pkg;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } func3_e;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    localparam int unsigned PC_INCR = 32'd4;

    // Saturating step of a 2-bit counter toward the resolved direction.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        case (ctr)
            CTR_SNT: nxt = taken ? CTR_WNT : CTR_SNT;
            CTR_WNT: nxt = taken ? CTR_WT  : CTR_SNT;
            CTR_WT:  nxt = taken ? CTR_ST  : CTR_WNT;
            CTR_ST:  nxt = taken ? CTR_ST  : CTR_WT;
            default: nxt = CTR_WNT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/branch_bht.sv
// Branch history table: one 2-bit saturating counter per entry, a combinational
// lookup port and a single clocked update port (lookup sees pre-update state).
module branch_bht
    import branch_pkg::*;
#(
    parameter int BHT_DEPTH = 64,
    parameter int IDX_W     = $clog2(BHT_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] lookup_idx,
    output logic             lookup_taken,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    logic [1:0] ctr_r [BHT_DEPTH];

    // Counter array: all entries weakly not-taken out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                ctr_r[i] <= CTR_WNT;
            end
        end else if (upd_en) begin
            ctr_r[upd_idx] <= ctr_next(ctr_r[upd_idx], upd_taken);
        end
    end

    assign lookup_taken = ctr_r[lookup_idx][1];

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolution: evaluates the condition, registers outcome/redirect/mispredict
// one cycle later and counts mispredictions. BRANCH_PREDICT_EN enables the BHT.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] fetch_pc,
    output logic            pred_taken,
    input  logic            ex_valid,
    input  logic [2:0]      ex_func3,
    input  logic [XLEN-1:0] ex_op1,
    input  logic [XLEN-1:0] ex_op2,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic            ex_pred_taken,
    output logic            res_valid,
    output logic            res_taken,
    output logic            mispredict,
    output logic            illegal,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     mispredict_count
);

    localparam int              IDX_W   = $clog2(BHT_DEPTH);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(PC_INCR);
    localparam logic [31:0]     CNT_MAX = 32'hFFFF_FFFF;

    logic            cond_s;
    logic            illegal_s;
    logic            taken_s;
    logic            mispredict_s;
    logic            bht_upd_s;
    logic [XLEN-1:0] target_s;
    logic [XLEN-1:0] fall_s;
    logic [XLEN-1:0] redirect_s;

    logic            res_valid_r;
    logic            res_taken_r;
    logic            mispredict_r;
    logic            illegal_r;
    logic [XLEN-1:0] redirect_pc_r;
    logic [31:0]     count_r;

    // Condition evaluation; unsupported codes resolve not-taken and flag illegal.
    always_comb begin
        cond_s    = 1'b0;
        illegal_s = 1'b0;
        case (ex_func3)
            F3_BEQ:  cond_s = (ex_op1 == ex_op2);
            F3_BNE:  cond_s = (ex_op1 != ex_op2);
            F3_BLT:  cond_s = ($signed(ex_op1) <  $signed(ex_op2));
            F3_BGE:  cond_s = ($signed(ex_op1) >= $signed(ex_op2));
            F3_BLTU: cond_s = (ex_op1 <  ex_op2);
            F3_BGEU: cond_s = (ex_op1 >= ex_op2);
            default: illegal_s = 1'b1;
        endcase
    end

    // Next-state resolution values; adders wrap modulo 2^XLEN.
    always_comb begin
        target_s     = ex_pc + ex_imm;
        fall_s       = ex_pc + PC_STEP;
        taken_s      = cond_s & ~illegal_s;
        redirect_s   = taken_s ? target_s : fall_s;
        mispredict_s = ex_valid & ~illegal_s & (taken_s ^ ex_pred_taken);
        bht_upd_s    = ex_valid & ~illegal_s;
    end

    // Resolution registers; pulses drop when no branch was present.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid_r   <= 1'b0;
            res_taken_r   <= 1'b0;
            mispredict_r  <= 1'b0;
            illegal_r     <= 1'b0;
            redirect_pc_r <= {XLEN{1'b0}};
            count_r       <= 32'd0;
        end else begin
            res_valid_r  <= ex_valid;
            mispredict_r <= mispredict_s;
            illegal_r    <= ex_valid & illegal_s;
            if (ex_valid) begin
                res_taken_r   <= taken_s;
                redirect_pc_r <= redirect_s;
            end
            if (mispredict_s && (count_r != CNT_MAX)) begin
                count_r <= count_r + 32'd1;
            end
        end
    end

    assign res_valid        = res_valid_r;
    assign res_taken        = res_taken_r;
    assign mispredict       = mispredict_r;
    assign illegal          = illegal_r;
    assign redirect_pc      = redirect_pc_r;
    assign mispredict_count = count_r;

`ifdef BRANCH_PREDICT_EN
    logic unused_pc_bits_s;
    assign unused_pc_bits_s = ^{fetch_pc[XLEN-1:IDX_W+2], fetch_pc[1:0]};

    branch_bht #(
        .BHT_DEPTH (BHT_DEPTH),
        .IDX_W     (IDX_W)
    ) u_bht (
        .clk          (clk),
        .rst          (rst),
        .lookup_idx   (fetch_pc[IDX_W+1:2]),
        .lookup_taken (pred_taken),
        .upd_en       (bht_upd_s),
        .upd_idx      (ex_pc[IDX_W+1:2]),
        .upd_taken    (taken_s)
    );
`else
    // Static not-taken: no table, lookup inputs are intentionally ignored.
    logic unused_predict_s;
    assign unused_predict_s = ^{fetch_pc, bht_upd_s};
    assign pred_taken       = 1'b0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit; predictor expectations
// follow whether BRANCH_PREDICT_EN is defined for the build.
module tb_branch_resolve_unit;

`ifdef BRANCH_PREDICT_EN
    localparam logic PE = 1'b1;
`else
    localparam logic PE = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic        ex_valid;
    logic [2:0]  ex_func3;
    logic [31:0] ex_op1;
    logic [31:0] ex_op2;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm;
    logic        ex_pred_taken;
    logic        res_valid;
    logic        res_taken;
    logic        mispredict;
    logic        illegal;
    logic [31:0] redirect_pc;
    logic [31:0] mispredict_count;

    int checks   = 0;
    int failures = 0;

    branch_resolve_unit #(.XLEN(32), .BHT_DEPTH(64)) dut (
        .clk              (clk),
        .rst              (rst),
        .fetch_pc         (fetch_pc),
        .pred_taken       (pred_taken),
        .ex_valid         (ex_valid),
        .ex_func3         (ex_func3),
        .ex_op1           (ex_op1),
        .ex_op2           (ex_op2),
        .ex_pc            (ex_pc),
        .ex_imm           (ex_imm),
        .ex_pred_taken    (ex_pred_taken),
        .res_valid        (res_valid),
        .res_taken        (res_taken),
        .mispredict       (mispredict),
        .illegal          (illegal),
        .redirect_pc      (redirect_pc),
        .mispredict_count (mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic br(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] pc, input logic [31:0] imm, input logic p);
        ex_valid      = 1'b1;
        ex_func3      = f3;
        ex_op1        = a;
        ex_op2        = b;
        ex_pc         = pc;
        ex_imm        = imm;
        ex_pred_taken = p;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic res(input string tag, input logic tk, input logic [31:0] rpc,
                       input logic mp, input logic [31:0] cnt);
        chk({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
        chk({tag, "_taken"}, {31'd0, res_taken}, {31'd0, tk});
        chk({tag, "_redirect"}, redirect_pc, rpc);
        chk({tag, "_mispredict"}, {31'd0, mispredict}, {31'd0, mp});
        chk({tag, "_count"}, mispredict_count, cnt);
    endtask

    initial begin
        rst = 1'b1; fetch_pc = 32'h40; ex_valid = 1'b0; ex_func3 = 3'b000;
        ex_op1 = 32'd0; ex_op2 = 32'd0; ex_pc = 32'd0; ex_imm = 32'd0; ex_pred_taken = 1'b0;
        tick(); tick();
        chk("rst_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_redirect", redirect_pc, 32'd0);
        chk("rst_count", mispredict_count, 32'd0);
        chk("rst_pred", {31'd0, pred_taken}, 32'd0);
        rst = 1'b0;

        // Equal operands: taken, predicted not-taken
        br(3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0); tick();
        res("beq", 1'b1, 32'h120, 1'b1, 32'd1);
        chk("beq_illegal", {31'd0, illegal}, 32'd0);
        ex_valid = 1'b0; tick();
        chk("idle_valid", {31'd0, res_valid}, 32'd0);
        chk("idle_mispredict", {31'd0, mispredict}, 32'd0);
        chk("idle_hold_redirect", redirect_pc, 32'h120);
        chk("idle_hold_taken", {31'd0, res_taken}, 32'd1);

        // Signed vs unsigned compare, back to back
        br(3'b100, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h10, 1'b1); tick();
        res("blt", 1'b1, 32'h210, 1'b0, 32'd1);
        br(3'b110, 32'hFFFF_FFFF, 32'd1, 32'h300, 32'h10, 1'b1); tick();
        res("bltu", 1'b0, 32'h304, 1'b1, 32'd2);
        br(3'b001, 32'd3, 32'd3, 32'h500, 32'h40, 1'b0); tick();
        res("bne", 1'b0, 32'h504, 1'b0, 32'd2);
        br(3'b101, 32'h8000_0000, 32'd0, 32'h600, 32'd8, 1'b1); tick();
        res("bge", 1'b0, 32'h604, 1'b1, 32'd3);
        br(3'b111, 32'h8000_0000, 32'd0, 32'h700, 32'hFFFF_FFF0, 1'b1); tick();
        res("bgeu", 1'b1, 32'h6F0, 1'b0, 32'd3);
        br(3'b001, 32'd1, 32'd2, 32'hFFFF_FFFC, 32'd8, 1'b1); tick();
        res("wrap_target", 1'b1, 32'h4, 1'b0, 32'd3);
        br(3'b000, 32'd1, 32'd2, 32'hFFFF_FFFC, 32'd8, 1'b0); tick();
        res("wrap_fall", 1'b0, 32'h0, 1'b0, 32'd3);

        // Counter walk at pc 0x40: WNT->WT->ST->ST->WT->WNT
        chk("bht_init", {31'd0, pred_taken}, 32'd0);
        br(3'b000, 32'd7, 32'd7, 32'h40, 32'd4, 1'b0); tick();
        chk("bht_t1", {31'd0, pred_taken}, {31'd0, PE});
        res("bht_t1r", 1'b1, 32'h44, 1'b1, 32'd4);
        br(3'b000, 32'd7, 32'd7, 32'h40, 32'd4, 1'b1); tick();
        chk("bht_t2", {31'd0, pred_taken}, {31'd0, PE});
        tick();
        chk("bht_t3", {31'd0, pred_taken}, {31'd0, PE});
        chk("bht_t3_count", mispredict_count, 32'd4);
        br(3'b001, 32'd7, 32'd7, 32'h40, 32'd4, 1'b1); tick();
        chk("bht_n1", {31'd0, pred_taken}, {31'd0, PE});
        res("bht_n1r", 1'b0, 32'h44, 1'b1, 32'd5);
        br(3'b001, 32'd7, 32'd7, 32'h40, 32'd4, 1'b0); tick();
        chk("bht_n2", {31'd0, pred_taken}, 32'd0);

        // Same-index lookup/update: old value this cycle, new one next
        br(3'b000, 32'd7, 32'd7, 32'h40, 32'd4, 1'b0); #1;
        chk("same_old_t", {31'd0, pred_taken}, 32'd0);
        tick();
        chk("same_new_t", {31'd0, pred_taken}, {31'd0, PE});
        br(3'b001, 32'd7, 32'd7, 32'h40, 32'd4, 1'b1); #1;
        chk("same_old_n", {31'd0, pred_taken}, {31'd0, PE});
        tick();
        chk("same_new_n", {31'd0, pred_taken}, 32'd0);
        chk("same_count", mispredict_count, 32'd7);

        // Illegal codes leave the table alone
        br(3'b011, 32'd9, 32'd9, 32'h40, 32'd4, 1'b1); tick();
        res("ill011", 1'b0, 32'h44, 1'b0, 32'd7);
        chk("ill011_flag", {31'd0, illegal}, 32'd1);
        chk("ill011_pred", {31'd0, pred_taken}, 32'd0);
        br(3'b010, 32'd9, 32'd9, 32'h80, 32'd4, 1'b1); tick();
        chk("ill010_flag", {31'd0, illegal}, 32'd1);
        chk("ill010_taken", {31'd0, res_taken}, 32'd0);
        br(3'b000, 32'd7, 32'd7, 32'h40, 32'd4, 1'b1); tick();
        chk("post_ill_pred", {31'd0, pred_taken}, {31'd0, PE});
        chk("post_ill_flag", {31'd0, illegal}, 32'd0);
        chk("post_ill_count", mispredict_count, 32'd7);

        // Asynchronous reset mid-stream with a branch in flight
        br(3'b000, 32'd7, 32'd7, 32'h40, 32'd4, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, res_valid}, 32'd0);
        chk("arst_taken", {31'd0, res_taken}, 32'd0);
        chk("arst_redirect", redirect_pc, 32'd0);
        chk("arst_count", mispredict_count, 32'd0);
        chk("arst_pred", {31'd0, pred_taken}, 32'd0);
        tick();
        ex_valid = 1'b0;
        rst = 1'b0;
        tick();
        chk("after_rst_valid", {31'd0, res_valid}, 32'd0);
        chk("after_rst_mispredict", {31'd0, mispredict}, 32'd0);
        chk("after_rst_count", mispredict_count, 32'd0);
        chk("after_rst_pred", {31'd0, pred_taken}, 32'd0);
        br(3'b000, 32'd7, 32'd7, 32'h40, 32'd4, 1'b1); tick();
        chk("after_rst_wnt", {31'd0, pred_taken}, {31'd0, PE});
        res("after_rst_br", 1'b1, 32'h44, 1'b0, 32'd0);
        ex_valid = 1'b0; tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
